// File: rtl/rv32_pipe_pkg.sv
// rv32_pipe_pkg: shared fetch-side constants and the fetch sequencer state type
package rv32_pipe_pkg;
   localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] PC_INC = 32'd4;
   typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} fetch_state_t;
endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry instruction+pc buffer that catches an ack arriving while decode is stalled
//   load captures instr_in/pc_in and sets valid; drop clears valid; load wins over drop
module fetch_skid (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        drop,
   input  logic [31:0] instr_in,
   input  logic [31:0] pc_in,
   output logic        valid,
   output logic [31:0] instr,
   output logic [31:0] pc
);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         valid <= 1'b0;
         instr <= '0;
         pc <= '0;
      end else if (load) begin
         valid <= 1'b1;
         instr <= instr_in;
         pc <= pc_in;
      end else if (drop)
         valid <= 1'b0;
endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: owns the PC, runs a single-outstanding imem req/ack port and fills the fetch/decode register
//   stall_in/pc_sel_in/target_pc come from the hazard manager; imem_* is the instruction memory port;
//   instr_fd/pc_fd/pc_4_fd/valid_fd feed decode (valid_fd=0 marks a NOP bubble)
module fetch_seq
   import rv32_pipe_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_in,
   input  logic        pc_sel_in,
   input  logic [31:0] target_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_fd,
   output logic [31:0] pc_fd,
   output logic [31:0] pc_4_fd,
   output logic        valid_fd
);
   fetch_state_t state;
   logic [31:0] pc, redirect_pc, tgt, skid_instr, skid_pc;
   logic skid_valid;
   assign tgt = target_pc & ~32'h3;
   // pc only moves on ack or on a redirect taken with no fetch outstanding, so it doubles as the stable request address
   assign imem_addr = pc;
   assign pc_4_fd = pc_fd + PC_INC;
   fetch_skid u_skid (
      .clk(clk),
      .rst(rst),
      .load(state == FETCH && !pc_sel_in && imem_ack && stall_in),
      .drop(state == HOLD && (pc_sel_in || !stall_in)),
      .instr_in(imem_rdata),
      .pc_in(pc),
      .valid(skid_valid),
      .instr(skid_instr),
      .pc(skid_pc)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= BOOT;
         pc <= RESET_PC;
         redirect_pc <= RESET_PC;
         imem_req <= 1'b0;
         instr_fd <= NOP_INSTR;
         pc_fd <= RESET_PC;
         valid_fd <= 1'b0;
      end else
         unique case (state)
            BOOT: begin
               state <= FETCH;
               imem_req <= 1'b1;
            end
            FETCH:
               if (pc_sel_in && imem_ack) begin
                  pc <= tgt;
                  instr_fd <= NOP_INSTR;
                  valid_fd <= 1'b0;
               end else if (pc_sel_in) begin
                  redirect_pc <= tgt;
                  instr_fd <= NOP_INSTR;
                  valid_fd <= 1'b0;
                  state <= DRAIN;
               end else if (imem_ack && !stall_in) begin
                  instr_fd <= imem_rdata;
                  pc_fd <= pc;
                  valid_fd <= 1'b1;
                  pc <= pc + PC_INC;
               end else if (imem_ack) begin
                  pc <= pc + PC_INC;
                  imem_req <= 1'b0;
                  state <= HOLD;
               end else if (!stall_in) begin
                  instr_fd <= NOP_INSTR;
                  valid_fd <= 1'b0;
               end
            HOLD:
               if (pc_sel_in) begin
                  pc <= tgt;
                  instr_fd <= NOP_INSTR;
                  valid_fd <= 1'b0;
                  imem_req <= 1'b1;
                  state <= FETCH;
               end else if (!stall_in) begin
                  instr_fd <= skid_instr;
                  pc_fd <= skid_pc;
                  valid_fd <= skid_valid;
                  imem_req <= 1'b1;
                  state <= FETCH;
               end
            DRAIN: begin
               instr_fd <= NOP_INSTR;
               valid_fd <= 1'b0;
               if (imem_ack) begin
                  pc <= pc_sel_in ? tgt : redirect_pc;
                  state <= FETCH;
               end else if (pc_sel_in)
                  redirect_pc <= tgt;
            end
         endcase
endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: directed checks of fetch_seq against hand-computed fetch/decode sequences
module tb_fetch_seq;
   logic clk = 1'b0, rst = 1'b1, stall_in = 1'b0, pc_sel_in = 1'b0, auto_ack = 1'b0;
   logic [31:0] target_pc = '0;
   logic imem_req, imem_ack, valid_fd;
   logic [31:0] imem_addr, imem_rdata, instr_fd, pc_fd, pc_4_fd;
   int errors = 0, checks = 0;
   localparam logic [31:0] NOP = 32'h0000_0013;

   function automatic logic [31:0] ins(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   assign imem_ack = auto_ack & imem_req;
   assign imem_rdata = ins(imem_addr);

   always #5 clk = ~clk;

   fetch_seq dut (
      .clk(clk), .rst(rst), .stall_in(stall_in), .pc_sel_in(pc_sel_in), .target_pc(target_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_fd(instr_fd), .pc_fd(pc_fd), .pc_4_fd(pc_4_fd), .valid_fd(valid_fd)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step();
      step();
      checks++;
      if ({imem_req, imem_addr, instr_fd, pc_fd, valid_fd} !== {1'b0, 32'h0, NOP, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL reset: req=%b addr=%h instr=%h pc_fd=%h valid=%b", imem_req, imem_addr, instr_fd, pc_fd, valid_fd);
      end
      rst = 1'b0;
      auto_ack = 1'b1;
      step();
      checks++;
      if ({imem_req, imem_addr, valid_fd} !== {1'b1, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL boot: req=%b addr=%h valid=%b exp 1/00000000/0", imem_req, imem_addr, valid_fd);
      end
   endtask

   task automatic test_stream();
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if ({instr_fd, pc_fd, pc_4_fd, valid_fd, imem_addr} !== {ins(i * 4), 32'(i * 4), 32'(i * 4 + 4), 1'b1, 32'(i * 4 + 4)}) begin
            errors++;
            $display("FAIL stream%0d: instr=%h pc_fd=%h pc4=%h valid=%b addr=%h", i, instr_fd, pc_fd, pc_4_fd, valid_fd, imem_addr);
         end
      end
   endtask

   task automatic test_stall();
      stall_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({imem_req, instr_fd, pc_fd, valid_fd} !== {1'b0, ins(32'h4), 32'h4, 1'b1}) begin
            errors++;
            $display("FAIL stall%0d: req=%b instr=%h pc_fd=%h valid=%b exp 0/%h/4/1", i, imem_req, instr_fd, pc_fd, valid_fd, ins(32'h4));
         end
      end
      stall_in = 1'b0;
      step();
      checks++;
      if ({instr_fd, pc_fd, valid_fd, imem_req, imem_addr} !== {ins(32'h8), 32'h8, 1'b1, 1'b1, 32'hC}) begin
         errors++;
         $display("FAIL skid_out: instr=%h pc_fd=%h valid=%b req=%b addr=%h", instr_fd, pc_fd, valid_fd, imem_req, imem_addr);
      end
      step();
      checks++;
      if ({instr_fd, pc_fd, imem_addr} !== {ins(32'hC), 32'hC, 32'h10}) begin
         errors++;
         $display("FAIL after_stall: instr=%h pc_fd=%h addr=%h exp pc 0c addr 10", instr_fd, pc_fd, imem_addr);
      end
   endtask

   task automatic test_redirect_ack();
      for (int i = 0; i < 4; i++) step();
      checks++;
      if (imem_addr !== 32'h20) begin
         errors++;
         $display("FAIL reach20: addr=%h exp 00000020", imem_addr);
      end
      pc_sel_in = 1'b1;
      target_pc = 32'h100;
      step();
      pc_sel_in = 1'b0;
      checks++;
      if ({imem_addr, instr_fd, valid_fd} !== {32'h100, NOP, 1'b0}) begin
         errors++;
         $display("FAIL redir_ack: addr=%h instr=%h valid=%b exp 100/nop/0", imem_addr, instr_fd, valid_fd);
      end
      step();
      checks++;
      if ({instr_fd, pc_fd, valid_fd, imem_addr} !== {ins(32'h100), 32'h100, 1'b1, 32'h104}) begin
         errors++;
         $display("FAIL redir_ack_next: instr=%h pc_fd=%h valid=%b addr=%h", instr_fd, pc_fd, valid_fd, imem_addr);
      end
   endtask

   task automatic test_drain();
      auto_ack = 1'b0;
      pc_sel_in = 1'b1;
      target_pc = 32'h200;
      for (int i = 0; i < 3; i++) begin
         step();
         pc_sel_in = 1'b0;
         checks++;
         if ({imem_req, imem_addr, valid_fd} !== {1'b1, 32'h104, 1'b0}) begin
            errors++;
            $display("FAIL drain%0d: req=%b addr=%h valid=%b exp 1/104/0", i, imem_req, imem_addr, valid_fd);
         end
      end
      auto_ack = 1'b1;
      step();
      checks++;
      if ({imem_addr, valid_fd} !== {32'h200, 1'b0}) begin
         errors++;
         $display("FAIL drain_end: addr=%h valid=%b exp 200/0", imem_addr, valid_fd);
      end
      step();
      checks++;
      if ({instr_fd, pc_fd, valid_fd, imem_addr} !== {ins(32'h200), 32'h200, 1'b1, 32'h204}) begin
         errors++;
         $display("FAIL drain_next: instr=%h pc_fd=%h valid=%b addr=%h", instr_fd, pc_fd, valid_fd, imem_addr);
      end
   endtask

   task automatic test_double_redirect();
      auto_ack = 1'b0;
      pc_sel_in = 1'b1;
      target_pc = 32'h300;
      step();
      target_pc = 32'h400;
      step();
      pc_sel_in = 1'b0;
      auto_ack = 1'b1;
      checks++;
      if ({imem_addr, valid_fd} !== {32'h204, 1'b0}) begin
         errors++;
         $display("FAIL dbl_hold: addr=%h valid=%b exp 204/0", imem_addr, valid_fd);
      end
      step();
      checks++;
      if (imem_addr !== 32'h400) begin
         errors++;
         $display("FAIL dbl_redir: addr=%h exp 00000400", imem_addr);
      end
      step();
      checks++;
      if ({instr_fd, valid_fd} !== {ins(32'h400), 1'b1}) begin
         errors++;
         $display("FAIL dbl_next: instr=%h valid=%b", instr_fd, valid_fd);
      end
   endtask

   task automatic test_hold_redirect();
      stall_in = 1'b1;
      step();
      pc_sel_in = 1'b1;
      target_pc = 32'h500;
      step();
      pc_sel_in = 1'b0;
      stall_in = 1'b0;
      checks++;
      if ({imem_req, imem_addr, instr_fd, valid_fd} !== {1'b1, 32'h500, NOP, 1'b0}) begin
         errors++;
         $display("FAIL hold_redir: req=%b addr=%h instr=%h valid=%b exp 1/500/nop/0", imem_req, imem_addr, instr_fd, valid_fd);
      end
      step();
      checks++;
      if ({instr_fd, pc_fd, valid_fd} !== {ins(32'h500), 32'h500, 1'b1}) begin
         errors++;
         $display("FAIL hold_drop: instr=%h pc_fd=%h valid=%b exp pc 500", instr_fd, pc_fd, valid_fd);
      end
   endtask

   task automatic test_async_reset();
      auto_ack = 1'b0;
      pc_sel_in = 1'b1;
      target_pc = 32'h600;
      step();
      pc_sel_in = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({imem_req, imem_addr, instr_fd, pc_fd, pc_4_fd, valid_fd} !== {1'b0, 32'h0, NOP, 32'h0, 32'h4, 1'b0}) begin
         errors++;
         $display("FAIL async_rst: req=%b addr=%h instr=%h pc_fd=%h pc4=%h valid=%b", imem_req, imem_addr, instr_fd, pc_fd, pc_4_fd, valid_fd);
      end
      step();
      rst = 1'b0;
      auto_ack = 1'b1;
      step();
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
         errors++;
         $display("FAIL reboot: req=%b addr=%h exp 1/0", imem_req, imem_addr);
      end
   endtask

   task automatic test_align_wrap();
      pc_sel_in = 1'b1;
      target_pc = 32'h103;
      step();
      checks++;
      if (imem_addr !== 32'h100) begin
         errors++;
         $display("FAIL align: addr=%h exp 00000100", imem_addr);
      end
      target_pc = 32'hFFFF_FFFC;
      step();
      pc_sel_in = 1'b0;
      checks++;
      if ({imem_addr, valid_fd} !== {32'hFFFF_FFFC, 1'b0}) begin
         errors++;
         $display("FAIL wrap_tgt: addr=%h valid=%b exp fffffffc/0", imem_addr, valid_fd);
      end
      step();
      checks++;
      if ({instr_fd, pc_fd, pc_4_fd, valid_fd, imem_addr} !== {ins(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h0}) begin
         errors++;
         $display("FAIL wrap: instr=%h pc_fd=%h pc4=%h valid=%b addr=%h", instr_fd, pc_fd, pc_4_fd, valid_fd, imem_addr);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect_ack();
      test_drain();
      test_double_redirect();
      test_hold_redirect();
      test_async_reset();
      test_align_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
